// File: rtl/rf_pkg.sv
// Shared constants and types for the multi-port RV32 register file.
package rf_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int NREG_DEF    = 32;
  localparam int LINK_OFFSET = 4;

  typedef enum logic {
    CLEAR,
    RUN
  } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Post-reset clear sequencer: sweeps registers 1..NREG-1 to zero, then raises rf_ready.
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          rf_ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  rf_state_e     state, state_nx;
  logic [AW-1:0] clr_idx, clr_idx_nx;
  logic          rf_ready_nx;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous here, so it is tested inside the clocked branch
    // and not listed in the sensitivity list; all state uses <= so every flop
    // samples pre-edge values.
    if (!reset) begin
      state    <= CLEAR;
      clr_idx  <= AW'(1);
      rf_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      clr_idx  <= clr_idx_nx;
      rf_ready <= rf_ready_nx;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nx    = state;
    clr_idx_nx  = clr_idx;
    rf_ready_nx = rf_ready;
    clr_we      = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == AW'(NREG - 1)) begin
          state_nx    = RUN;
          rf_ready_nx = 1'b1;
        end else begin
          clr_idx_nx = clr_idx + 1'b1;
        end
      end
      RUN: begin
      end
    endcase
  end

  assign clr_addr = clr_idx;

endmodule

// File: rtl/rv_regfile_mp.sv
// Multi-port RV32 register file with JAL link port and self-clearing reset sweep.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module rv_regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                jal_en,
  input  logic [AW-1:0]       jal_rd,
  input  logic [XLEN-1:0]     jal_pc,
  output logic                rf_ready,
  output logic                wr_drop
);

  logic            clr_we;
  logic [AW-1:0]   clr_addr;
  logic [XLEN-1:0] link_val;
  logic [XLEN-1:0] mem    [1:NREG-1];
  logic [NREG-1:1] wr_hit;
  logic [XLEN-1:0] wr_val [1:NREG-1];
  logic [AW-1:0]   rd_a;

  rf_clear_seq #(.NREG(NREG), .AW(AW)) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .rf_ready (rf_ready),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign link_val = jal_pc + XLEN'(LINK_OFFSET);

  // Per-register winning write: link first, then general ports high-to-low so port 0 lands last.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      wr_hit[r] = 1'b0;
      wr_val[r] = '0;
      if (jal_en && jal_rd == AW'(r)) begin
        wr_hit[r] = 1'b1;
        wr_val[r] = link_val;
      end
      for (int p = NWR - 1; p >= 0; p--) begin
        if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r)) begin
          wr_hit[r] = 1'b1;
          wr_val[r] = wr_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the array has no reset term; the clear sweep zeroes it after reset,
    // which keeps it mappable onto plain RAM/flops without reset wiring.
    if (reset) begin
      for (int r = 1; r < NREG; r++) begin
        if (clr_we && clr_addr == AW'(r)) begin
          mem[r] <= '0;
        end else if (rf_ready && wr_hit[r]) begin
          mem[r] <= wr_val[r];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= !rf_ready && (|wr_en || jal_en);
    end
  end

  // Reads are forced to zero while the sweep runs and for x0.
  always_comb begin
    rd_data = '0;
    rd_a    = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_a = rd_addr[i*AW +: AW];
      if (rf_ready && rd_a != '0) begin
`ifdef RF_BYPASS_EN
        rd_data[i*XLEN +: XLEN] = wr_hit[rd_a] ? wr_val[rd_a] : mem[rd_a];
`else
        rd_data[i*XLEN +: XLEN] = mem[rd_a];
`endif
      end
    end
  end

endmodule

// File: tb/tb_rv_regfile_mp.sv
// Self-checking bench for rv_regfile_mp against a behavioural register-file model.
module tb_rv_regfile_mp;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 1;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                jal_en;
  logic [AW-1:0]       jal_rd;
  logic [XLEN-1:0]     jal_pc;
  logic                rf_ready;
  logic                wr_drop;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] m_mem [NREG];
  bit              m_ready;
  int              m_swept;
  bit              m_drop;

  rv_regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .jal_en   (jal_en),
    .jal_rd   (jal_rd),
    .jal_pc   (jal_pc),
    .rf_ready (rf_ready),
    .wr_drop  (wr_drop)
  );

  always #5 clk = ~clk;

  // Architectural model: after reset the file is all zero and becomes usable
  // after NREG-1 reset-free edges; writes land afterwards, general port beats link.
  task automatic model_edge();
    if (!reset) begin
      m_ready = 0;
      m_swept = 0;
      m_drop  = 0;
      for (int i = 0; i < NREG; i++) m_mem[i] = '0;
    end else begin
      m_drop = !m_ready && (wr_en[0] || jal_en);
      if (!m_ready) begin
        m_swept++;
        if (m_swept == NREG - 1) m_ready = 1;
      end else begin
        if (jal_en && jal_rd != 0) m_mem[jal_rd] = jal_pc + 32'd4;
        if (wr_en[0] && wr_addr != 0) m_mem[wr_addr] = wr_data;
      end
    end
  endtask

  function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
    if (!m_ready || a == 0) return '0;
`ifdef RF_BYPASS_EN
    if (wr_en[0] && wr_addr == a) return wr_data;
    if (jal_en && jal_rd == a) return jal_pc + 32'd4;
`endif
    return m_mem[a];
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en  = '0;
    jal_en = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    set_rd(3, 17);
    repeat (3) step();
    checks++;
    if (rf_ready !== 1'b0 || wr_drop !== 1'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_state ready=%b drop=%b rd=%h required 0/0/0", rf_ready, wr_drop, rd_data);
    end
    reset = 1'b1;
    for (int e = 1; e <= NREG - 1; e++) begin
      if (e == 10) begin
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hCAFE0005;
      end else begin
        idle();
      end
      step();
      checks++;
      if (rf_ready !== (e == NREG - 1) || wr_drop !== (e == 10)) begin
        failures++;
        $display("FAIL clear_edge%0d ready=%b drop=%b required %b/%b", e, rf_ready, wr_drop,
                 e == NREG - 1, e == 10);
      end
    end
    idle();
    for (int r = 1; r < NREG; r++) begin
      set_rd(r, NREG - r);
      checks++;
      if (rd_data !== '0) begin
        failures++;
        $display("FAIL cleared_x%0d rd=%h required 0", r, rd_data);
      end
    end
  endtask

  task automatic test_basic();
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEADBEEF;
    step();
    idle();
    set_rd(7, 0);
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_x7 got=%h required DEADBEEF", rd_data[31:0]);
    end
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
    step();
    idle();
    set_rd(0, 7);
    checks++;
    if (rd_data !== {32'hDEADBEEF, 32'h0}) begin
      failures++;
      $display("FAIL basic_x0 got=%h required DEADBEEF00000000", rd_data);
    end
  endtask

  task automatic test_link();
    jal_en = 1'b1; jal_rd = 1; jal_pc = 32'h00000100;
    step();
    idle();
    set_rd(1, 1);
    checks++;
    if (rd_data[31:0] !== 32'h00000104) begin
      failures++;
      $display("FAIL link_x1 got=%h required 00000104", rd_data[31:0]);
    end
    jal_en = 1'b1; jal_rd = 1; jal_pc = 32'hFFFFFFFC;
    step();
    idle();
    set_rd(1, 1);
    checks++;
    if (rd_data[63:32] !== 32'h0) begin
      failures++;
      $display("FAIL link_wrap got=%h required 00000000", rd_data[63:32]);
    end
  endtask

  task automatic test_conflict();
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h11;
    jal_en = 1'b1; jal_rd = 3; jal_pc = 32'h200;
    step();
    idle();
    set_rd(3, 0);
    checks++;
    if (rd_data[31:0] !== 32'h11) begin
      failures++;
      $display("FAIL conflict_x3 got=%h required 00000011", rd_data[31:0]);
    end
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] req;
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h12345678;
    step();
    wr_data = 32'hA5A5A5A5;
    set_rd(0, 9);
`ifdef RF_BYPASS_EN
    req = 32'hA5A5A5A5;
`else
    req = 32'h12345678;
`endif
    checks++;
    if (rd_data[63:32] !== req) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h required %h", rd_data[63:32], req);
    end
    step();
    idle();
    set_rd(0, 9);
    checks++;
    if (rd_data[63:32] !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL bypass_after got=%h required A5A5A5A5", rd_data[63:32]);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e;
    for (int n = 0; n < 400; n++) begin
      reset   = ($urandom_range(0, 149) != 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
      jal_en  = ($urandom_range(0, 3) == 0);
      jal_rd  = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 7));
      jal_pc  = $urandom;
      set_rd($urandom_range(0, 7), ($urandom_range(0, 1) == 1) ? int'(wr_addr) : $urandom_range(0, 7));
      for (int i = 0; i < NRD; i++) begin
        e = exp_read(rd_addr[i*AW +: AW]);
        checks++;
        if (rd_data[i*XLEN +: XLEN] !== e) begin
          failures++;
          $display("FAIL random_rd%0d it=%0d addr=%0d got=%h required %h", i, n,
                   rd_addr[i*AW +: AW], rd_data[i*XLEN +: XLEN], e);
        end
      end
      step();
      checks++;
      if (rf_ready !== m_ready || wr_drop !== m_drop) begin
        failures++;
        $display("FAIL random_ctl it=%0d ready=%b drop=%b required %b/%b", n, rf_ready, wr_drop,
                 m_ready, m_drop);
      end
    end
    reset = 1'b1;
    idle();
    while (!m_ready) step();
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    idle();
    step();
    reset = 1'b1;
    repeat (15) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int e = 1; e <= NREG - 1; e++) begin
      step();
      checks++;
      if (rf_ready !== (e == NREG - 1)) begin
        failures++;
        $display("FAIL midsweep_edge%0d ready=%b required %b", e, rf_ready, e == NREG - 1);
      end
    end
    wr_en = 1'b1; wr_addr = 4; wr_data = 32'h55;
    step();
    idle();
    set_rd(4, 0);
    checks++;
    if (rd_data[31:0] !== 32'h55) begin
      failures++;
      $display("FAIL run_x4 got=%h required 00000055", rd_data[31:0]);
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if (rf_ready !== 1'b0 || rd_data[31:0] !== 32'h0) begin
      failures++;
      $display("FAIL run_reset ready=%b x4=%h required 0/00000000", rf_ready, rd_data[31:0]);
    end
    for (int e = 1; e <= NREG - 1; e++) begin
      step();
      checks++;
      if (rf_ready !== (e == NREG - 1)) begin
        failures++;
        $display("FAIL run_sweep_edge%0d ready=%b required %b", e, rf_ready, e == NREG - 1);
      end
    end
    set_rd(4, 4);
    checks++;
    if (rd_data !== '0) begin
      failures++;
      $display("FAIL run_x4_cleared got=%h required 0", rd_data);
    end
  endtask

  initial begin
    reset   = 1'b0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    wr_data = '0;
    jal_en  = 1'b0;
    jal_rd  = '0;
    jal_pc  = '0;
    test_reset();
    test_basic();
    test_link();
    test_conflict();
    test_bypass();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_regfile_mp.md
# rv_regfile_mp

Parametrised multi-port integer register file for the pipelined RV32 core. It is the successor to the single-write pipeline register file: a clocked write path, N read and N general write ports, and a dedicated JAL link port that computes `pc+4` itself. It also has a self-sequenced post-reset clear and optional write-to-read bypass. It sits between decode (reads) and writeback (writes), with the link port driven from the jump stage.

## Interface
Parameters:
- `XLEN`, 32: data width.
- `NREG`, 32: register count, power of two, ≥4; `AW = $clog2(NREG)`.
- `NRD`, 2: number of read ports.
- `NWR`, 1: number of general write ports.

Ports:
- `clk`  input  1: rising-edge clock.
- `reset`  input  1: reset, synchronous, active-low.
- `rd_addr`  input  NRD*AW: read addresses. Port i occupies bits `[i*AW +: AW]`.
- `rd_data`  output  NRD*XLEN: read data. Combinational from `rd_addr`.
- `wr_en`  input  NWR: per-port write enable.
- `wr_addr`  input  NWR*AW: write addresses.
- `wr_data`  input  NWR*XLEN: write data.
- `jal_en`  input  1: link write request.
- `jal_rd`  input  AW: link destination register.
- `jal_pc`  input  XLEN: PC of the jump instruction.
- `rf_ready`  output  1: clear sequence complete; writes are accepted.
- `wr_drop`  output  1: registered pulse, asserted the cycle after any write request is discarded because `rf_ready`=0.

## Operation
- Two-state FSM: CLEAR and RUN.
- **Reset** (`reset`=0 at a posedge):
  - state ← CLEAR, `clr_idx` ← 1.
  - `rf_ready` ← 0, `wr_drop` ← 0.
  - Array contents are not touched on the reset edge itself.
- **CLEAR:**
  - Each posedge with `reset`=1 writes 0 to `mem[clr_idx]`.
  - If `clr_idx`==NREG-1: state ← RUN and `rf_ready` ← 1. Otherwise `clr_idx` increments.
  - All write requests are discarded and raise `wr_drop`.
  - All `rd_data` lanes read 0.
- **RUN:**
  - Each posedge commits every enabled write whose address is ≠0.
  - The link write value is `jal_pc + 4`, truncated modulo 2^XLEN (so 0xFFFFFFFC → 0x00000000).
- **Register 0:** always reads 0 and is never written. No storage is required for it.
- **Same-address conflict in one cycle:** the link port has lowest priority; among general ports, the lower index wins. Exactly one value is committed.
- **Reads:**
  - `rd_data[i]` = `mem[rd_addr[i]]`, or 0 when the address is 0.
  - Addresses ≥ NREG cannot occur because NREG is a power of two.
- **Reset mid-CLEAR:** the sweep restarts from register 1.
- **Reset in RUN:** the full sweep is re-run; the file never holds stale data once `rf_ready`=1.

## Timing
- **Write latency:** a write is visible in the array after the posedge at which it is presented.
- **Clear duration:** if `reset` is sampled 1 first at edge k, edges k … k+NREG-2 clear registers 1 … NREG-1. `rf_ready` rises after edge k+NREG-2 (31 edges for NREG=32).
- **Reset values:** `rf_ready`=0, `wr_drop`=0, all `rd_data`=0.
- **Read path:** zero-cycle, combinational. No handshake on reads.
- **Write-side handshake:** producers hold off while `rf_ready`=0. A dropped request is not retried by this block.

## Configuration
- `RF_BYPASS_EN` defined:
  - A read whose address matches an enabled, nonzero write address in the same cycle returns the winning write's data, resolved with the same priority rule as writes.
  - Bypass applies only in RUN.
- `RF_BYPASS_EN` undefined:
  - Reads return the pre-edge array value.
  - The pipeline must resolve the same-cycle write-then-read hazard externally.

## Structure
- Package `rf_pkg`:
  - Default `XLEN`/`NREG` constants.
  - `rf_state_e` enum {CLEAR, RUN}.
  - A `LINK_OFFSET`=4 constant.
- Sub-module `rf_clear_seq`:
  - Contains the FSM, `clr_idx` counter, `rf_ready` and the clear-write strobe/address.
  - The top level merges the clear strobe with the write ports and the read-zero muxing.

## Test plan
- **Post-reset clear:** hold `reset`=0 for 3 cycles, then release.
  - `rf_ready` rises exactly 31 edges later.
  - Reading registers 1–31 gives 0.
  - A write to x5 issued at cycle 10 raises `wr_drop` and x5 stays 0.
- **Basic write/read:** write x7=0xDEADBEEF on port 0 → the next cycle, `rd_data[0]` reads 0xDEADBEEF from address 7. A write to x0 is ignored and x0 reads 0.
- **Link port:**
  - `jal_en`, `jal_rd`=1, `jal_pc`=0x00000100 → x1=0x00000104.
  - `jal_pc`=0xFFFFFFFC → x1=0x00000000.
- **Conflict:** same cycle, `wr_en[0]` writes x3=0x11 and the link port writes x3 (`pc`=0x200) → x3=0x11.
- **Bypass:** write x9=0xA5A5A5A5 while `rd_addr[1]`=9 in the same cycle.
  - With `RF_BYPASS_EN`: `rd_data[1`]=0xA5A5A5A5 in that cycle.
  - Without it: the old value is returned.
- **Reset mid-sweep and in RUN:** pulse `reset` low at clear step 15 → `rf_ready` rises 31 edges after release. In RUN with x4=0x55, pulse reset → x4 reads 0 and `rf_ready`=0 until the sweep completes.
